// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int unsigned MAX_W = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      FIX  = 3'd2,
      DONE = 3'd3
   } state_e;

   // Two's-complement magnitude; callers truncate to their own operand width.
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic neg);
      return neg ? MAX_W'(-x) : x;
   endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface seq_mult_param_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prod;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, prod
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, prod
   );

endinterface

// File: rtl/seq_mult_param_shift_add_dp.sv
// Shift-add datapath: accumulator, multiplier shift register and (WIDTH+1)-bit adder.
module shift_add_dp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     mcand_in,
   input  logic [WIDTH-1:0]     mplr_in,
   output logic [2*WIDTH-1:0]   prod_raw
);

   logic [WIDTH:0]   acc_q, acc_d, sum;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;

   // Add when the multiplier LSB is set, then shift {acc,mplr} right with the carry kept.
   always_comb begin
      sum     = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      if (load) begin
         acc_d   = '0;
         mcand_d = mcand_in;
         mplr_d  = mplr_in;
      end else if (step) begin
         acc_d  = {1'b0, sum[WIDTH:1]};
         mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
      end
   end

   assign prod_raw = {acc_q[WIDTH-1:0], mplr_q};

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, unsigned or two's-complement, fixed WIDTH+2 cycle latency.
module seq_mult_param
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   seq_mult_param_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [PW-1:0]     prod_raw;
   logic              dp_load, dp_step;
   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  mcand_in, mplr_in;

   // Operands enter the datapath as magnitudes; the sign is reapplied in FIX.
   always_comb begin
      a_neg    = bus.signed_mode & bus.a[WIDTH-1];
      b_neg    = bus.signed_mode & bus.b[WIDTH-1];
      mcand_in = WIDTH'(abs_val(MAX_W'(bus.a), a_neg));
      mplr_in  = WIDTH'(abs_val(MAX_W'(bus.b), b_neg));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      busy_d  = busy_q;
      prod_d  = prod_q;
      done_d  = (state_q == DONE);
      dp_load = 1'b0;
      dp_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = CALC;
               cnt_d   = '0;
               neg_d   = a_neg ^ b_neg;
               busy_d  = 1'b1;
               dp_load = 1'b1;
            end
         end
         CALC: begin
            dp_step = 1'b1;
            cnt_d   = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            prod_d  = neg_q ? -prod_raw : prod_raw;
            busy_d  = 1'b0;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end

   shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (dp_load),
      .step     (dp_step),
      .mcand_in (mcand_in),
      .mplr_in  (mplr_in),
      .prod_raw (prod_raw)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.prod = prod_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: WIDTH=8 and WIDTH=4 instances against a timeline/arithmetic model.
module tb_seq_mult_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_mult_param_if #(.WIDTH(8)) bus8 ();
   seq_mult_param_if #(.WIDTH(4)) bus4 ();

   seq_mult_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   seq_mult_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   logic        s_start [2];
   logic        s_sm    [2];
   logic [31:0] s_a     [2];
   logic [31:0] s_b     [2];

   assign bus8.start       = s_start[0];
   assign bus8.signed_mode = s_sm[0];
   assign bus8.a           = s_a[0][7:0];
   assign bus8.b           = s_b[0][7:0];
   assign bus4.start       = s_start[1];
   assign bus4.signed_mode = s_sm[1];
   assign bus4.a           = s_a[1][3:0];
   assign bus4.b           = s_b[1][3:0];

   logic        d_busy [2];
   logic        d_done [2];
   logic [63:0] d_prod [2];
   assign d_busy[0] = bus8.busy;
   assign d_done[0] = bus8.done;
   assign d_prod[0] = 64'(bus8.prod);
   assign d_busy[1] = bus4.busy;
   assign d_done[1] = bus4.done;
   assign d_prod[1] = 64'(bus4.prod);

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wdt(input int i);
      return (i == 0) ? 8 : 4;
   endfunction

   // Plain-arithmetic product of the operands as interpreted in the selected mode.
   function automatic logic [63:0] model_prod(input int w, input logic sm,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, mask;
      mask = (longint'(1) << w) - 1;
      sa = longint'(a) & mask;
      sb = longint'(b) & mask;
      if (sm && a[w-1]) sa = sa - (longint'(1) << w);
      if (sm && b[w-1]) sb = sb - (longint'(1) << w);
      return 64'(sa * sb) & ((64'(1) << (2 * w)) - 1);
   endfunction

   // Timeline model: accept at edge t0, prod/busy change at t0+W+1, done pulse after t0+W+2.
   int          cyc = 0;
   int          t0       [2] = '{0, 0};
   int          ready_at [2] = '{0, 0};
   bit          pend     [2] = '{0, 0};
   logic [63:0] pprod    [2] = '{0, 0};
   logic [63:0] e_prod   [2] = '{0, 0};
   bit          e_busy   [2] = '{0, 0};
   bit          e_done   [2] = '{0, 0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            pend[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_prod[i] = '0; ready_at[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            e_done[i] = pend[i] && (cyc == t0[i] + wdt(i) + 2);
            if (e_done[i]) pend[i] = 0;
            if (pend[i] && cyc == t0[i] + wdt(i) + 1) begin
               e_prod[i] = pprod[i];
               e_busy[i] = 0;
            end
            if (s_start[i] && cyc >= ready_at[i]) begin
               t0[i]       = cyc;
               pend[i]     = 1;
               e_busy[i]   = 1;
               pprod[i]    = model_prod(wdt(i), s_sm[i], s_a[i], s_b[i]);
               ready_at[i] = cyc + wdt(i) + 3;
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("busy%0d", i), 64'(d_busy[i]), 64'(e_busy[i]));
         chk($sformatf("done%0d", i), 64'(d_done[i]), 64'(e_done[i]));
         chk($sformatf("prod%0d", i), d_prod[i], e_prod[i]);
      end
   end

   // Called #1 after an edge; returns #1 after the edge that raised done.
   task automatic run_op(input int i, input logic sm, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output logic [63:0] p);
      s_sm[i] = sm; s_a[i] = a; s_b[i] = b; s_start[i] = 1'b1;
      @(posedge clk);
      #1 s_start[i] = 1'b0;
      busy_cnt = d_busy[i] ? 1 : 0;
      lat = -1;
      p = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (d_done[i]) begin
            lat = k;
            p = d_prod[i];
            break;
         end
         if (d_busy[i]) busy_cnt++;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout%0d: got no done expected done within 40 cycles", i);
      end
   endtask

   task automatic op(input int i, input logic sm, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input string tag);
      int lat, bc;
      logic [63:0] p;
      run_op(i, sm, a, b, lat, bc, p);
      chk({tag, "_lat"}, 64'(lat), 64'(wdt(i) + 2));
      chk({tag, "_prod"}, p, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      int lat, bc, nd, i, gap;
      logic sm;
      logic [31:0] ra, rb;
      logic [63:0] p;
      for (int k = 0; k < 2; k++) begin
         s_start[k] = 0; s_sm[k] = 0; s_a[k] = '0; s_b[k] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("rst_busy8", 64'(d_busy[0]), 64'd0);
      chk("rst_done8", 64'(d_done[0]), 64'd0);
      chk("rst_prod8", d_prod[0], 64'd0);
      chk("rst_prod4", d_prod[1], 64'd0);
      @(posedge clk);
      #1;

      run_op(0, 1'b0, 32'd255, 32'd255, lat, bc, p);
      chk("u255_lat", 64'(lat), 64'd10);
      chk("u255_busy_cycles", 64'(bc), 64'd9);
      chk("u255_prod", p, 64'hFE01);

      op(0, 1'b1, 32'h80, 32'h80, 64'h4000, "s_m128sq");
      op(0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, "s_m3x5");
      op(0, 1'b1, 32'h7F, 32'hFF, 64'hFF81, "s_127xm1");
      op(0, 1'b0, 32'h00, 32'hA5, 64'h0000, "u_0xA5");
      op(0, 1'b0, 32'h01, 32'hA5, 64'h00A5, "u_1xA5_b2b");

      // Extra starts during CALC and DONE must be ignored.
      s_sm[0] = 0; s_a[0] = 6; s_b[0] = 7; s_start[0] = 1;
      @(posedge clk);
      #1 s_start[0] = 0;
      nd = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (d_done[0]) begin
            nd++;
            chk("ign_prod", d_prod[0], 64'd42);
         end
         if (k == 3) begin s_start[0] = 1; s_a[0] = 99; s_b[0] = 77; s_sm[0] = 1; end
         if (k == 4) s_start[0] = 0;
         if (k == 9) begin s_start[0] = 1; s_a[0] = 5; s_b[0] = 5; end
         if (k == 10) s_start[0] = 0;
      end
      chk("ign_done_count", 64'(nd), 64'd1);

      // Asynchronous reset in the middle of CALC.
      s_sm[0] = 0; s_a[0] = 200; s_b[0] = 3; s_start[0] = 1;
      @(posedge clk);
      #1 s_start[0] = 0;
      repeat (5) @(posedge clk);
      #3;
      chk("pre_rst_busy", 64'(d_busy[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(d_busy[0]), 64'd0);
      chk("arst_done", 64'(d_done[0]), 64'd0);
      chk("arst_prod", d_prod[0], 64'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      nd = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (d_done[0]) nd++;
      end
      chk("arst_no_done", 64'(nd), 64'd0);
      op(0, 1'b0, 32'd13, 32'd11, 64'd143, "post_rst");

      op(1, 1'b0, 32'hF, 32'hF, 64'hE1, "w4_u15sq");
      op(1, 1'b1, 32'h8, 32'h8, 64'h40, "w4_s_m8sq");
      op(1, 1'b1, 32'h8, 32'h7, 64'hC8, "w4_s_m8x7");

      for (int n = 0; n < 60; n++) begin
         i   = int'($urandom_range(0, 1));
         sm  = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         op(i, sm, ra, rb, model_prod(wdt(i), sm, ra, rb), $sformatf("rnd%0d", n));
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
